// File: rtl/shaper_peak_controller_pkg.sv
// Shared settings for the shaper peak controller.
// Default widths and the controller state encoding.
package package_settings;

    localparam int SIZE_SHAPER_DATA           = 16;
    localparam int SIZE_TIME_MAXIMUM_SEARCH   = 8;
    localparam int SIZE_INTEGRAL_TIME_COUNTER = 16;
    localparam int SIZE_EVENT_COUNTER         = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SEARCH,
        ST_REPORT,
        ST_DEAD
    } state_t;

endpackage

// File: rtl/shaper_peak_controller_if.sv
// Statistic counter bundle: increment/clear in, count out.
interface shaper_peak_controller_if #(
    parameter int W = package_settings::SIZE_EVENT_COUNTER
);

    logic         inc;
    logic         clear;
    logic [W-1:0] count;

    modport master (
        output inc,
        output clear,
        input  count
    );

    modport slave (
        input  inc,
        input  clear,
        output count
    );

endinterface

// File: rtl/event_statistic_counter.sv
// Saturating event counter with a synchronous clear.
module event_statistic_counter #(
    parameter int W = package_settings::SIZE_EVENT_COUNTER
) (
    input  logic                     clk,
    input  logic                     reset_n,
    shaper_peak_controller_if.slave  stat
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear dominates a coincident increment.
    always_comb begin
        count_d = count_q;
        if (stat.clear) begin
            count_d = '0;
        end else if (stat.inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stat.count = count_q;

endmodule

// File: rtl/shaper_peak_controller.sv
// Trapezoid peak finder: arm, search a window, report, dead time.
// Accepted and pile-up events are counted by two statistic counters.
module shaper_peak_controller #(
    parameter int SIZE_SHAPER_DATA =
        package_settings::SIZE_SHAPER_DATA,
    parameter int SIZE_TIME_MAXIMUM_SEARCH =
        package_settings::SIZE_TIME_MAXIMUM_SEARCH,
    parameter int SIZE_INTEGRAL_TIME_COUNTER =
        package_settings::SIZE_INTEGRAL_TIME_COUNTER,
    parameter int SIZE_EVENT_COUNTER =
        package_settings::SIZE_EVENT_COUNTER
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic                                   counter_clear,
    input  logic signed [SIZE_SHAPER_DATA-1:0]     shaper_data,
    input  logic                                   shaper_data_valid,
    input  logic signed [SIZE_SHAPER_DATA-1:0]     threshold,
    input  logic [SIZE_TIME_MAXIMUM_SEARCH-1:0]    search_time,
    input  logic [SIZE_INTEGRAL_TIME_COUNTER-1:0]  dead_time,
    output logic signed [SIZE_SHAPER_DATA-1:0]     peak_data,
    output logic                                   peak_valid,
    output logic                                   pile_up,
    output logic                                   busy,
    output logic [SIZE_EVENT_COUNTER-1:0]          event_counter,
    output logic [SIZE_EVENT_COUNTER-1:0]          pile_up_counter
);

    import package_settings::*;

    localparam int SDW = SIZE_SHAPER_DATA;
    localparam int STW = SIZE_TIME_MAXIMUM_SEARCH;
    localparam int DTW = SIZE_INTEGRAL_TIME_COUNTER;

    state_t                state_q, state_d;
    logic signed [SDW-1:0] max_q, max_d;
    logic signed [SDW-1:0] thr_q, thr_d;
    logic signed [SDW-1:0] hold_q, hold_d;
    logic [STW-1:0]        win_cnt_q, win_cnt_d;
    logic [STW-1:0]        win_len_q, win_len_d;
    logic [DTW-1:0]        dead_cnt_q, dead_cnt_d;
    logic [DTW-1:0]        dead_len_q, dead_len_d;
    logic                  below_q, below_d;
    logic                  pile_q, pile_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            max_q      <= '0;
            thr_q      <= '0;
            hold_q     <= '0;
            win_cnt_q  <= '0;
            win_len_q  <= '0;
            dead_cnt_q <= '0;
            dead_len_q <= '0;
            below_q    <= 1'b0;
            pile_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            thr_q      <= thr_d;
            hold_q     <= hold_d;
            win_cnt_q  <= win_cnt_d;
            win_len_q  <= win_len_d;
            dead_cnt_q <= dead_cnt_d;
            dead_len_q <= dead_len_d;
            below_q    <= below_d;
            pile_q     <= pile_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        thr_d      = thr_q;
        hold_d     = hold_q;
        win_cnt_d  = win_cnt_q;
        win_len_d  = win_len_q;
        dead_cnt_d = dead_cnt_q;
        dead_len_d = dead_len_q;
        below_d    = below_q;
        pile_d     = pile_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (shaper_data_valid && (shaper_data > threshold)) begin
                    state_d   = ST_SEARCH;
                    max_d     = shaper_data;
                    thr_d     = threshold;
                    win_cnt_d = STW'(1);
                    win_len_d = (search_time == '0) ? STW'(1) : search_time;
                    below_d   = 1'b0;
                    pile_d    = 1'b0;
                end
            end
            ST_SEARCH: begin
                // A one-sample window is already full on entry.
                if (win_cnt_q >= win_len_q) begin
                    state_d = ST_REPORT;
                end else if (shaper_data_valid) begin
                    win_cnt_d = win_cnt_q + STW'(1);
                    if (shaper_data > max_q) begin
                        max_d = shaper_data;
                    end
                    if (shaper_data > thr_q) begin
                        if (below_q) begin
                            pile_d = 1'b1;
                        end
                    end else begin
                        below_d = 1'b1;
                    end
                    if (win_cnt_d == win_len_q) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (!pile_q) begin
                    hold_d = max_q;
                end
                dead_cnt_d = '0;
                dead_len_d = dead_time;
                state_d    = (dead_time != '0) ? ST_DEAD : ST_ARMED;
            end
            ST_DEAD: begin
                if (shaper_data_valid) begin
                    dead_cnt_d = dead_cnt_q + DTW'(1);
                    if (dead_cnt_d == dead_len_q) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The report cycle always completes, even if run control drops.
        if (!enable && (state_q != ST_REPORT)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        busy       = 1'b0;
        peak_valid = 1'b0;
        pile_up    = 1'b0;
        peak_data  = hold_q;
        unique case (state_q)
            ST_REPORT: begin
                busy       = 1'b1;
                peak_valid = !pile_q;
                pile_up    = pile_q;
                if (!pile_q) begin
                    peak_data = max_q;
                end
            end
            ST_SEARCH,
            ST_DEAD: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    shaper_peak_controller_if #(.W(SIZE_EVENT_COUNTER)) evt_if ();
    shaper_peak_controller_if #(.W(SIZE_EVENT_COUNTER)) pu_if ();

    assign evt_if.inc   = peak_valid;
    assign evt_if.clear = counter_clear;
    assign pu_if.inc    = pile_up;
    assign pu_if.clear  = counter_clear;

    event_statistic_counter #(.W(SIZE_EVENT_COUNTER)) u_evt_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .stat    (evt_if.slave)
    );

    event_statistic_counter #(.W(SIZE_EVENT_COUNTER)) u_pu_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .stat    (pu_if.slave)
    );

    assign event_counter   = evt_if.count;
    assign pile_up_counter = pu_if.count;

endmodule
